// File: rtl/my_mic_axil_v2.sv
// my_mic_axil_v2: AXI4-Lite register block fronting a microphone sample FIFO.
// Word map: 0 CTRL, 1 STATUS (W1C overflow), 2 SAMPLE (read pops), 3 THRESH,
// 4..NUM_REGS-1 SCRATCH. A level interrupt fires on FIFO threshold or overflow.
module my_mic_axil_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter int FIFO_DEPTH         = 16,
  parameter int SAMPLE_WIDTH       = 24
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic                            sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]         sample_data,
  output logic                            irq
);

  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int SW = $clog2(NUM_REGS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [31:0] NREG    = NUM_REGS;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  // write channel latches and response
  logic           aw_full;
  logic [IW-1:0]  aw_idx;
  logic           w_full;
  logic [31:0]    w_data;
  logic [3:0]     w_strb;
  logic           bvalid_q;
  logic [1:0]     bresp_q;

  // read channel
  logic           rvalid_q;
  logic [31:0]    rdata_q;
  logic [1:0]     rresp_q;
  logic [IW-1:0]  ar_idx;
  logic [31:0]    rd_mux;
  logic           rd_err;

  // register state
  logic           cap_en;
  logic           irq_en;
  logic           overflow;
  logic [8:0]     thresh;
  logic [31:0]    scratch [NUM_REGS];

  // sample FIFO
  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic           fifo_empty;
  logic           fifo_full;

  logic           irq_q;

  // handshake and event decode
  logic aw_rdy, w_rdy, ar_rdy;
  logic wr_fire, wr_ok, ar_fire;
  logic clear_now, pop_now, try_push, push_now, ovf_set, ovf_clr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ready outputs are forced low while reset is held
  assign aw_rdy  = !ARESET && !aw_full && !bvalid_q;
  assign w_rdy   = !ARESET && !w_full  && !bvalid_q;
  assign ar_rdy  = !ARESET && !rvalid_q;

  assign wr_fire = aw_full && w_full && !bvalid_q;
  assign wr_ok   = 32'(aw_idx) < NREG;
  assign ar_idx  = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_fire = s_axi_arvalid && ar_rdy;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));

  // clear wins over push and pop in the same cycle; a pop frees room for a push
  assign clear_now = wr_fire && (aw_idx == IW'(0)) && w_strb[0] && w_data[1];
  assign pop_now   = ar_fire && (ar_idx == IW'(2)) && !fifo_empty && !clear_now;
  assign try_push  = sample_valid && cap_en && !clear_now;
  assign push_now  = try_push && (!fifo_full || pop_now);
  assign ovf_set   = try_push && fifo_full && !pop_now;
  assign ovf_clr   = wr_fire && (aw_idx == IW'(1)) && w_strb[0] && w_data[2];

  // capture AW and W independently, respond once both are held
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      if (s_axi_awvalid && aw_rdy) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (s_axi_wvalid && w_rdy) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
        bresp_q  <= OKAY;
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
      end
    end
  end

  // register file update with per-byte strobes; overflow is sticky until W1C
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cap_en   <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) scratch[i] <= '0;
    end else begin
      if (wr_fire && wr_ok) begin
        if (aw_idx == IW'(0) && w_strb[0]) begin
          cap_en <= w_data[0];
          irq_en <= w_data[2];
        end
        if (aw_idx == IW'(3)) begin
          if (w_strb[0]) thresh[7:0] <= w_data[7:0];
          if (w_strb[1]) thresh[8]   <= w_data[8];
        end
        if (aw_idx >= IW'(4)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) scratch[aw_idx[SW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_now) wr_ptr <= wr_ptr + 1'b1;
      if (pop_now)  rd_ptr <= rd_ptr + 1'b1;
      if (push_now && !pop_now)      level <= level + 1'b1;
      else if (pop_now && !push_now) level <= level - 1'b1;
    end
  end

  // sample storage, no reset needed since occupancy guards every read
  always_ff @(posedge ACLK) begin
    if (push_now) mem[wr_ptr] <= sample_data;
  end

  // read data selection for the address on the AR channel
  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    if (32'(ar_idx) >= NREG) begin
      rd_err = 1'b1;
    end else begin
      case (ar_idx)
        IW'(0):  rd_mux = {29'd0, irq_en, 1'b0, cap_en};
        IW'(1):  rd_mux = {15'd0, 9'(level), 5'd0, overflow, fifo_full, fifo_empty};
        IW'(2):  rd_mux = fifo_empty ? '0 : 32'(mem[rd_ptr]);
        IW'(3):  rd_mux = {23'd0, thresh};
        default: rd_mux = scratch[ar_idx[SW-1:0]];
      endcase
    end
  end

  // registered read response, held until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
      rresp_q  <= rd_err ? SLVERR : OKAY;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // interrupt level: threshold reached (non-zero threshold) or overflow, when enabled
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq_q <= 1'b0;
    else        irq_q <= irq_en && (((32'(level) >= 32'(thresh)) && (thresh != '0)) || overflow);
  end

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = w_rdy;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ar_rdy;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_my_mic_axil_v2.sv
// Bench for my_mic_axil_v2: directed scenarios plus randomized register/sample
// traffic, checked by a response scoreboard fed from a behavioural model.
module tb_my_mic_axil_v2;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam int FD = 16;
  localparam int SW = 24;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [31:0]   s_axi_wdata = '0;
  logic [3:0]    s_axi_wstrb = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [31:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          irq;

  always #5 ACLK = ~ACLK;

  my_mic_axil_v2 #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
    .FIFO_DEPTH(FD), .SAMPLE_WIDTH(SW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .sample_valid(sample_valid), .sample_data(sample_data), .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;
  int b_done = 0;
  int r_done = 0;
  bit auto_ready = 1'b1;

  typedef struct packed {logic [31:0] data; logic [1:0] resp;} rsp_t;
  logic [1:0] exp_b[$];
  rsp_t       exp_r[$];

  // behavioural model of the register map and sample queue
  logic [31:0]   m_scr [NR];
  logic          m_cap, m_ien, m_ovf;
  logic [8:0]    m_thr;
  logic [SW-1:0] m_fifo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no handshake, required within cycle budget at %0t", name, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  function automatic logic m_irq();
    return m_ien && (((m_fifo.size() >= int'(m_thr)) && (m_thr != 0)) || m_ovf);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_scr[i] = '0;
    m_cap = 1'b0; m_ien = 1'b0; m_ovf = 1'b0; m_thr = '0;
    m_fifo.delete();
    exp_b.delete();
    exp_r.delete();
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    if (idx >= NR) begin exp_b.push_back(2'b10); return; end
    exp_b.push_back(2'b00);
    case (idx)
      0: if (s[0]) begin m_cap = d[0]; m_ien = d[2]; if (d[1]) m_fifo.delete(); end
      1: if (s[0] && d[2]) m_ovf = 1'b0;
      2: ;
      3: begin t = merge({23'd0, m_thr}, d, s); m_thr = t[8:0]; end
      default: m_scr[idx] = merge(m_scr[idx], d, s);
    endcase
  endtask

  task automatic model_read(input int idx);
    rsp_t r;
    r.data = '0;
    r.resp = 2'b00;
    if (idx >= NR) r.resp = 2'b10;
    else case (idx)
      0: r.data = {29'd0, m_ien, 1'b0, m_cap};
      1: r.data = (32'(m_fifo.size()) << 8) |
                  {29'd0, m_ovf, (m_fifo.size() == FD), (m_fifo.size() == 0)};
      2: if (m_fifo.size() > 0) r.data = 32'(m_fifo.pop_front());
      3: r.data = 32'(m_thr);
      default: r.data = m_scr[idx];
    endcase
    exp_r.push_back(r);
  endtask

  task automatic model_push(input logic [SW-1:0] d);
    if (m_cap) begin
      if (m_fifo.size() == FD) m_ovf = 1'b1;
      else m_fifo.push_back(d);
    end
  endtask

  // monitor: compare every presented response against the scoreboard head
  logic b_hold = 1'b0;
  logic r_hold = 1'b0;
  always @(negedge ACLK) begin
    if (ARESET) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (b_hold) check("bvalid_held", 32'(s_axi_bvalid), 32'd1);
      if (r_hold) check("rvalid_held", 32'(s_axi_rvalid), 32'd1);
      if (s_axi_bvalid) begin
        if (exp_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_unexpected: bvalid=1 bresp=%0d, required no response", s_axi_bresp);
        end else begin
          check("bresp", 32'(s_axi_bresp), 32'(exp_b[0]));
          if (s_axi_bready) begin void'(exp_b.pop_front()); b_done++; end
        end
      end
      if (s_axi_rvalid) begin
        if (exp_r.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL r_unexpected: rvalid=1 rdata=0x%08h, required no response", s_axi_rdata);
        end else begin
          check("rdata", s_axi_rdata, exp_r[0].data);
          check("rresp", 32'(s_axi_rresp), 32'(exp_r[0].resp));
          if (s_axi_rready) begin void'(exp_r.pop_front()); r_done++; end
        end
      end
      b_hold = s_axi_bvalid && !s_axi_bready;
      r_hold = s_axi_rvalid && !s_axi_rready;
    end
  end

  // random response back-pressure
  initial forever begin
    @(posedge ACLK); #1;
    if (auto_ready) begin
      s_axi_bready = ($urandom_range(0, 3) != 0);
      s_axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    int start;
    start = b_done;
    model_write(idx, d, s);
    fork
      begin
        repeat (aw_dly) @(posedge ACLK);
        #1; s_axi_awaddr = AW'(idx * 4); s_axi_awvalid = 1'b1;
        @(negedge ACLK);
        for (int c = 0; c < 100 && !s_axi_awready; c++) @(negedge ACLK);
        if (!s_axi_awready) timeout("aw_handshake");
        @(posedge ACLK); #1; s_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(posedge ACLK);
        #1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        @(negedge ACLK);
        for (int c = 0; c < 100 && !s_axi_wready; c++) @(negedge ACLK);
        if (!s_axi_wready) timeout("w_handshake");
        @(posedge ACLK); #1; s_axi_wvalid = 1'b0;
      end
    join
    for (int c = 0; c < 300 && b_done == start; c++) @(negedge ACLK);
    if (b_done == start) timeout("b_response");
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input int idx);
    int start;
    start = r_done;
    model_read(idx);
    s_axi_araddr = AW'(idx * 4); s_axi_arvalid = 1'b1;
    @(negedge ACLK);
    for (int c = 0; c < 100 && !s_axi_arready; c++) @(negedge ACLK);
    if (!s_axi_arready) timeout("ar_handshake");
    @(posedge ACLK); #1; s_axi_arvalid = 1'b0;
    @(negedge ACLK);
    check("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
    for (int c = 0; c < 300 && r_done == start; c++) @(negedge ACLK);
    if (r_done == start) timeout("r_response");
    @(posedge ACLK); #1;
  endtask

  task automatic push_samples(input int n);
    for (int i = 0; i < n; i++) begin
      sample_data = SW'($urandom());
      sample_valid = 1'b1;
      model_push(sample_data);
      @(posedge ACLK); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic check_irq();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("irq", 32'(irq), 32'(m_irq()));
    @(posedge ACLK); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op, idx, n;
    logic [31:0] d;
    logic [3:0]  s;

    model_reset();
    #1 ARESET = 1'b1;
    #2;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready",  32'(s_axi_wready),  32'd0);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("rst_rdata",   s_axi_rdata,        32'd0);
    check("rst_irq",     32'(irq),           32'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    for (int i = 0; i < 10; i++) axi_read(i);

    // scratch write/readback
    for (int i = 0; i < 4; i++) axi_write(4 + i, 32'(i + 1), 4'hF, i, 3 - i);
    for (int i = 0; i < 4; i++) axi_read(4 + i);

    // byte strobes
    axi_write(4, 32'h0, 4'hF, 0, 0);
    axi_write(4, 32'hAABB_CCDD, 4'b0101, 0, 0);
    axi_read(4);
    axi_write(5, 32'hFFFF_FFFF, 4'h0, 1, 0);
    axi_read(5);

    // out-of-range word
    axi_read(8);
    axi_write(8, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(15);

    // threshold interrupt and ordered pops
    axi_write(3, 32'd3, 4'hF, 0, 0);
    axi_write(0, 32'h5, 4'hF, 0, 0);
    push_samples(2);
    sample_data = SW'($urandom());
    sample_valid = 1'b1;
    model_push(sample_data);
    @(posedge ACLK); #1; sample_valid = 1'b0;
    @(negedge ACLK);
    check("irq_before", 32'(irq), 32'd0);
    @(negedge ACLK);
    check("irq_after_third", 32'(irq), 32'd1);
    @(posedge ACLK); #1;
    for (int i = 0; i < 3; i++) axi_read(2);
    axi_read(1);
    axi_read(2);
    check_irq();

    // overflow and W1C
    axi_write(0, 32'h3, 4'h1, 0, 0);
    push_samples(FD + 1);
    axi_read(1);
    axi_write(1, 32'h4, 4'hF, 0, 0);
    axi_read(1);
    axi_write(0, 32'h2, 4'h1, 0, 0);
    axi_read(1);

    // AW three cycles ahead of W, bready held low while bvalid waits
    auto_ready = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b1;
    fork
      axi_write(6, 32'h1234_5678, 4'hF, 0, 3);
      begin
        repeat (12) @(posedge ACLK); #1;
        check("bvalid_waiting", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
      end
    join
    auto_ready = 1'b1;
    axi_read(6);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        idx = $urandom_range(0, 9);
        d = $urandom();
        s = 4'($urandom());
        if (idx == 0 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
        if (idx == 3 && $urandom_range(0, 1) != 0) d[8:0] = 9'($urandom_range(0, FD));
        axi_write(idx, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (op < 7) begin
        axi_read($urandom_range(0, 9));
      end else begin
        n = $urandom_range(1, 6);
        push_samples(n);
      end
      if (it % 5 == 0) check_irq();
    end

    // reset while a read response is stalled
    auto_ready = 1'b0;
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b1;
    model_read(4);
    s_axi_araddr = AW'(16); s_axi_arvalid = 1'b1;
    @(negedge ACLK);
    for (int c = 0; c < 100 && !s_axi_arready; c++) @(negedge ACLK);
    if (!s_axi_arready) timeout("ar_before_reset");
    @(posedge ACLK); #1; s_axi_arvalid = 1'b0;
    @(negedge ACLK);
    check("rvalid_before_reset", 32'(s_axi_rvalid), 32'd1);
    @(posedge ACLK); #1 ARESET = 1'b1;
    #1;
    check("rvalid_in_reset", 32'(s_axi_rvalid), 32'd0);
    check("irq_in_reset", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      check("no_stale_rvalid", 32'(s_axi_rvalid), 32'd0);
    end
    @(posedge ACLK); #1;
    auto_ready = 1'b1;
    axi_read(4);
    axi_read(0);
    axi_read(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
